// File: rtl/dcache_wb_if.sv
// dcache_wb_if: request/response and memory-block bus of the write-back data cache.
//   slave  : cache view (takes MEM-stage requests, issues block reads/writes)
//   master : environment view (MEM-stage requester plus block memory)
//   CPU side   : data_address_2DC, read_2DC, write_2DC, data_write_2DC,
//                data_write_size_2DC, flush_2DC -> data_read_fDC, data_valid_fDC, flush_done
//   Memory side: block_address_2DM, block_write_2DM, dBlkRead, dBlkWrite
//                <- block_read_fDM, block_read_fDM_valid, block_write_fDM_valid
interface dcache_wb_if;
    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned WORD_W  = 32;
    localparam int unsigned BLOCK_W = 256;

    logic [ADDR_W-1:0]  data_address_2DC;
    logic               read_2DC;
    logic               write_2DC;
    logic [WORD_W-1:0]  data_write_2DC;
    logic [1:0]         data_write_size_2DC;
    logic               flush_2DC;
    logic [WORD_W-1:0]  data_read_fDC;
    logic               data_valid_fDC;
    logic               flush_done;
    logic [ADDR_W-1:0]  block_address_2DM;
    logic [BLOCK_W-1:0] block_write_2DM;
    logic               dBlkRead;
    logic               dBlkWrite;
    logic [BLOCK_W-1:0] block_read_fDM;
    logic               block_read_fDM_valid;
    logic               block_write_fDM_valid;

    modport slave (
        input  data_address_2DC, read_2DC, write_2DC, data_write_2DC,
               data_write_size_2DC, flush_2DC,
               block_read_fDM, block_read_fDM_valid, block_write_fDM_valid,
        output data_read_fDC, data_valid_fDC, flush_done,
               block_address_2DM, block_write_2DM, dBlkRead, dBlkWrite
    );

    modport master (
        output data_address_2DC, read_2DC, write_2DC, data_write_2DC,
               data_write_size_2DC, flush_2DC,
               block_read_fDM, block_read_fDM_valid, block_write_fDM_valid,
        input  data_read_fDC, data_valid_fDC, flush_done,
               block_address_2DM, block_write_2DM, dBlkRead, dBlkWrite
    );
endinterface

// File: rtl/dcache_wb.sv
// dcache_wb: direct-mapped write-back/write-allocate data cache, 256-bit lines.
//   CLK        : sole clock, rising edge
//   RESET      : synchronous active-low; clears valid/dirty, returns to IDLE
//   bus        : dcache_wb_if.slave (MEM-stage request port + block memory port)
//   hit_count, miss_count : request hit/miss counters, present only when
//                           DCACHE_PERF_EN is defined
// Hits complete combinationally in IDLE; misses go through WRITEBACK (dirty
// victim) and FILL, then the held request hits in IDLE. Words are big-endian
// within a line (word 0 in bits [255:224], byte 0 in bits [31:24] of a word).
module dcache_wb #(
    parameter int unsigned LINES = 32
) (
    input  logic        CLK,
    input  logic        RESET,
    dcache_wb_if.slave  bus
`ifdef DCACHE_PERF_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);
    localparam int unsigned IDX_W   = $clog2(LINES);
    localparam int unsigned TAG_W   = 32 - 5 - IDX_W;
    localparam int unsigned WORD_W  = 32;
    localparam int unsigned BLOCK_W = 256;

    typedef enum logic [2:0] {IDLE, WRITEBACK, FILL, FLUSH_SCAN, FLUSH_WB} state_t;

    state_t             state, stateNext;
    logic [IDX_W-1:0]   flushIdx, flushIdxNext;
    logic               flushDoneReg, flushDoneNext;
    logic [LINES-1:0]   validBits, dirtyBits;
    logic [BLOCK_W-1:0] dataMem [LINES];
    logic [TAG_W-1:0]   tagMem  [LINES];

    logic [IDX_W-1:0]   reqIndex;
    logic [TAG_W-1:0]   reqTag;
    logic [7:0]         wordBase;
    logic [1:0]         reqByte;
    logic               reqActive, lineHit, lineDirty, lastIdx;
    logic [BLOCK_W-1:0] reqLine, storeLine;
    logic [WORD_W-1:0]  mergedWord;
    int                 storeBytes, lane;

    logic               dataValid, blkRead, blkWrite;
    logic [WORD_W-1:0]  dataRead;
    logic [31:0]        blkAddr;
    logic [BLOCK_W-1:0] blkData;
    logic               doStore, doFill, doInval;

    // Address decode; word w lives at bits [32*(7-w) +: 32], and 7-w == ~w.
    assign reqIndex  = bus.data_address_2DC[IDX_W+4:5];
    assign reqTag    = bus.data_address_2DC[31:IDX_W+5];
    assign wordBase  = {~bus.data_address_2DC[4:2], 5'd0};
    assign reqByte   = bus.data_address_2DC[1:0];
    assign reqActive = bus.read_2DC | bus.write_2DC;
    assign reqLine   = dataMem[reqIndex];
    assign lineHit   = validBits[reqIndex] && (tagMem[reqIndex] == reqTag);
    assign lineDirty = validBits[reqIndex] && dirtyBits[reqIndex];
    assign lastIdx   = (flushIdx == IDX_W'(LINES - 1));

    // Store merge: low N bytes of store data land big-endian from addr[1:0], clipped at word end.
    always_comb begin
        mergedWord = reqLine[wordBase +: WORD_W];
        storeBytes = (bus.data_write_size_2DC == 2'd0) ? 4 : int'(bus.data_write_size_2DC);
        lane       = 0;
        for (int k = 0; k < 4; k++) begin
            lane = int'(reqByte) + k;
            if (k < storeBytes && lane < 4) begin
                mergedWord[8*(3-lane) +: 8] = bus.data_write_2DC[8*(storeBytes-1-k) +: 8];
            end
        end
        storeLine = reqLine;
        storeLine[wordBase +: WORD_W] = mergedWord;
    end

    // State register and valid/dirty bookkeeping.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state        <= IDLE;
            flushIdx     <= '0;
            flushDoneReg <= 1'b0;
            validBits    <= '0;
            dirtyBits    <= '0;
        end else begin
            state        <= stateNext;
            flushIdx     <= flushIdxNext;
            flushDoneReg <= flushDoneNext;
            if (doFill) begin
                validBits[reqIndex] <= 1'b1;
                dirtyBits[reqIndex] <= 1'b0;
            end
            if (doStore) begin
                dirtyBits[reqIndex] <= 1'b1;
            end
            if (doInval) begin
                validBits[flushIdx] <= 1'b0;
                dirtyBits[flushIdx] <= 1'b0;
            end
        end
    end

    // Line data and tags carry no reset; writes are blocked while RESET is low.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            if (doFill) begin
                dataMem[reqIndex] <= bus.block_read_fDM;
                tagMem[reqIndex]  <= reqTag;
            end else if (doStore) begin
                dataMem[reqIndex] <= storeLine;
            end
        end
    end

    // Next-state and bus outputs.
    always_comb begin
        stateNext     = state;
        flushIdxNext  = flushIdx;
        flushDoneNext = 1'b0;
        dataValid     = 1'b0;
        dataRead      = '0;
        blkRead       = 1'b0;
        blkWrite      = 1'b0;
        blkAddr       = '0;
        blkData       = '0;
        doStore       = 1'b0;
        doFill        = 1'b0;
        doInval       = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.flush_2DC) begin
                    stateNext    = FLUSH_SCAN;
                    flushIdxNext = '0;
                end else if (reqActive) begin
                    if (lineHit) begin
                        dataValid = 1'b1;
                        doStore   = bus.write_2DC;
                        if (bus.read_2DC) begin
                            dataRead = reqLine[wordBase +: WORD_W];
                        end
                    end else if (lineDirty) begin
                        stateNext = WRITEBACK;
                    end else begin
                        stateNext = FILL;
                    end
                end else begin
                    dataValid = 1'b1;
                end
            end
            WRITEBACK: begin
                blkWrite = 1'b1;
                blkAddr  = {tagMem[reqIndex], reqIndex, 5'd0};
                blkData  = reqLine;
                if (bus.block_write_fDM_valid) begin
                    stateNext = FILL;
                end
            end
            FILL: begin
                blkRead = 1'b1;
                blkAddr = {bus.data_address_2DC[31:5], 5'd0};
                if (bus.block_read_fDM_valid) begin
                    doFill    = 1'b1;
                    stateNext = IDLE;
                end
            end
            FLUSH_SCAN: begin
                if (validBits[flushIdx] && dirtyBits[flushIdx]) begin
                    stateNext = FLUSH_WB;
                end else begin
                    doInval      = 1'b1;
                    flushIdxNext = flushIdx + IDX_W'(1);
                    if (lastIdx) begin
                        stateNext     = IDLE;
                        flushDoneNext = 1'b1;
                    end
                end
            end
            FLUSH_WB: begin
                blkWrite = 1'b1;
                blkAddr  = {tagMem[flushIdx], flushIdx, 5'd0};
                blkData  = dataMem[flushIdx];
                if (bus.block_write_fDM_valid) begin
                    doInval      = 1'b1;
                    flushIdxNext = flushIdx + IDX_W'(1);
                    if (lastIdx) begin
                        stateNext     = IDLE;
                        flushDoneNext = 1'b1;
                    end else begin
                        stateNext = FLUSH_SCAN;
                    end
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    assign bus.data_valid_fDC    = dataValid;
    assign bus.data_read_fDC     = dataRead;
    assign bus.dBlkRead          = blkRead;
    assign bus.dBlkWrite         = blkWrite;
    assign bus.block_address_2DM = blkAddr;
    assign bus.block_write_2DM   = blkData;
    assign bus.flush_done        = flushDoneReg;

`ifdef DCACHE_PERF_EN
    logic        fillReplay, hitEvt, missEvt;
    logic [31:0] hitCnt, missCnt;

    // The hit that replays a request after its fill was already counted as a miss.
    assign hitEvt  = (state == IDLE) && !bus.flush_2DC && reqActive && lineHit && !fillReplay;
    assign missEvt = (state == IDLE) && !bus.flush_2DC && reqActive && !lineHit;

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            fillReplay <= 1'b0;
            hitCnt     <= '0;
            missCnt    <= '0;
        end else begin
            fillReplay <= doFill;
            if (hitEvt) begin
                hitCnt <= hitCnt + 32'd1;
            end
            if (missEvt) begin
                missCnt <= missCnt + 32'd1;
            end
        end
    end

    assign hit_count  = hitCnt;
    assign miss_count = missCnt;
`endif
endmodule

// File: doc/dcache_wb.md
DCACHE_WB -- requirements
Module: dcache_wb

Interface
REQ-001 SHALL have parameter LINES, default 32, number of direct-mapped 256-bit lines; power of 2, 2..1024.
REQ-002 SHALL have port CLK  in  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port RESET  in  1  reset, synchronous, active-low.
REQ-004 SHALL have port data_address_2DC  in  32  byte address from MEM stage.
REQ-005 SHALL have ports read_2DC / write_2DC  in  1 each  load / store request; both high is illegal.
REQ-006 SHALL have port data_write_2DC  in  32  store data.
REQ-007 SHALL have port data_write_size_2DC  in  2  store bytes: 1, 2, 3, or 0 meaning 4.
REQ-008 SHALL have port flush_2DC  in  1  write back and invalidate all lines.
REQ-009 SHALL have ports data_read_fDC  out  32  load data, and data_valid_fDC  out  1  request complete.
REQ-010 SHALL have ports block_address_2DM  out  32  32-byte-aligned block address, and block_write_2DM  out  256  victim line.
REQ-011 SHALL have ports dBlkRead / dBlkWrite  out  1 each  block read / write request.
REQ-012 SHALL have ports block_read_fDM  in  256  fill data, and block_read_fDM_valid / block_write_fDM_valid  in  1 each  block read / write done.
REQ-013 SHALL have port flush_done  out  1  one-cycle pulse when flush completes.

Function
REQ-014 Address split SHALL be: offset[4:0], index[log2(LINES)+4:5], tag = remaining upper bits; word w = addr[4:2] at block bits [255-32w:224-32w].
REQ-015 Byte lanes SHALL be big-endian: byte offset 0 = bits [31:24]; store of N bytes writes low N bytes of data_write_2DC starting at addr[1:0], clipped at word end.
REQ-016 FSM states SHALL be IDLE, WRITEBACK, FILL, FLUSH_SCAN, FLUSH_WB.
REQ-017 IDLE hit (line valid, tag equal): data_valid_fDC=1 combinationally in the same cycle; load data on data_read_fDC; store merged at the clock edge and line marked dirty.
REQ-018 No request: data_valid_fDC SHALL be 1; it SHALL be 0 only while a request is pending or flush is active.
REQ-019 Miss to dirty line: IDLE->WRITEBACK; dBlkWrite=1, victim address/data held until block_write_fDM_valid, then ->FILL.
REQ-020 Miss to clean/invalid line: IDLE->FILL; dBlkRead=1 until block_read_fDM_valid; line installed valid, clean, tag updated; ->IDLE, where the request then hits.
REQ-021 Requester SHALL hold address, data and controls stable while data_valid_fDC=0; cache samples them only in IDLE.
REQ-022 flush_2DC high in IDLE SHALL enter FLUSH_SCAN; it takes priority over a simultaneous read/write, which is served after flush_done.
REQ-023 FLUSH_SCAN SHALL visit index 0..LINES-1, one per cycle; dirty valid line -> FLUSH_WB (block write as REQ-019), then resume at next index; every visited line invalidated.
REQ-024 After index LINES-1: flush_done=1 for one cycle, ->IDLE; index counter wraps to 0.
REQ-025 block_*_valid asserted while not requested SHALL be ignored; dBlkRead and dBlkWrite never both high.

Reset
REQ-026 RESET low at a rising edge SHALL clear all valid and dirty bits, force IDLE, and drive dBlkRead=0, dBlkWrite=0, flush_done=0, data_read_fDC=0 from the next cycle, including mid-WRITEBACK/FILL/flush; the in-flight transaction is abandoned.
REQ-027 Clearing SHALL complete in the reset cycle; the first access after reset misses.

Configuration
REQ-028 Macro DCACHE_PERF_EN defined: SHALL add outputs hit_count and miss_count (32 each), zeroed by reset, incremented once per hit/miss request, wrapping at 2^32.
REQ-029 DCACHE_PERF_EN undefined: those ports and counters SHALL be absent; all other behaviour identical.

Verification
REQ-030 Reset, LINES=32; read 0x1000, memory returns block whose word 0 = 0xDEADBEEF -> one dBlkRead for address 0x1000, data_read_fDC=0xDEADBEEF, data_valid_fDC=1.
REQ-031 Store byte 0xAB to 0x1001, then load 0x1000 -> 0xDEAB BEEF in one cycle, no block traffic.
REQ-032 Dirty 0x1000, read 0x2000 (same index) -> dBlkWrite at 0x1000 with merged line, then dBlkRead at 0x2000.
REQ-033 flush_2DC with lines 0 and 5 dirty -> exactly two dBlkWrite transactions; flush_done after LINES+ (two write-back) cycles; next access misses.
REQ-034 RESET asserted during FILL with block_read_fDM_valid withheld -> dBlkRead=0 next cycle; re-read of 0x1000 misses.
REQ-035 DCACHE_PERF_EN defined, scenario REQ-030 then REQ-031 -> miss_count=1, hit_count=2.
